// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port text VRAM arbiter: display scan, host writer and clear engine
// Display slots always win; host writes and clear-engine writes use the remaining cycles.
module vram_arbiter #(
  parameter int                ADDR_W      = 13,
  parameter int                DATA_W      = 8,
  parameter int                COLS        = 80,
  parameter int                ROWS        = 30,
  parameter int                CELL_W_LOG2 = 3,
  parameter int                CELL_H_LOG2 = 4,
  parameter logic [DATA_W-1:0] CLR_CHAR    = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_tick,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] char_out,
  output logic              char_valid
);

  localparam int CELLS = COLS * ROWS;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              slot_q;
  logic              char_valid_q;
  logic [DATA_W-1:0] char_q;
  logic              disp_slot;
  logic [ADDR_W-1:0] disp_addr;

  assign disp_slot = p_tick && (pixel_x < 10'd640) && (pixel_y < 10'd480)
                     && (pixel_x[CELL_W_LOG2-1:0] == '0);

  // Computed at 32 bits, then truncated to the RAM address width.
  assign disp_addr = ADDR_W'(32'(pixel_y >> CELL_H_LOG2) * 32'(COLS)
                             + 32'(pixel_x >> CELL_W_LOG2));

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    wr_ack    = 1'b0;
    if (disp_slot) begin
      ram_addr = disp_addr;
    end
    if (state_q == S_IDLE) begin
      if (clr_req) begin
        state_d   = S_CLEAR;
        clr_cnt_d = '0;
      end else if (wr_req && !disp_slot) begin
        ram_addr  = wr_addr;
        ram_wdata = wr_data;
        ram_we    = !reset;
        wr_ack    = !reset;
      end
    end else begin
      if (!disp_slot) begin
        ram_addr  = clr_cnt_q;
        ram_wdata = CLR_CHAR;
        ram_we    = !reset;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(CELLS - 1)) begin
          state_d = S_IDLE;
        end
      end
    end
  end

  // Read data arrives one clock after the slot and is registered one clock later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      clr_cnt_q    <= '0;
      slot_q       <= 1'b0;
      char_valid_q <= 1'b0;
      char_q       <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      slot_q       <= disp_slot;
      char_valid_q <= slot_q;
      if (slot_q) begin
        char_q <= ram_rdata;
      end
    end
  end

  assign busy       = (state_q == S_CLEAR) && !reset;
  assign char_out   = char_q;
  assign char_valid = char_valid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - randomized self-checking bench for vram_arbiter
// A cell-level behavioural model predicts grants, clear progress and fetched characters.
module tb_vram_arbiter;

  localparam int CELLS = 80 * 30;

  logic        clk = 1'b0;
  logic        reset, p_tick, wr_req, clr_req, tb_init;
  logic [9:0]  px, py;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack, busy, ram_we, char_valid;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata, char_out;

  logic [7:0]  mem    [0:8191];
  logic [7:0]  shadow [0:8191];

  typedef struct {
    int         due;
    logic [7:0] val;
  } rd_t;
  rd_t rq[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   dut_acks = 0;
  int   nclr    = 0;
  bit   m_clr   = 0;
  int   m_ptr   = 0;
  bit   m_ack   = 0;
  logic [7:0] m_char = 8'h00;

  vram_arbiter dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .pixel_x(px), .pixel_y(py),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .clr_req(clr_req), .busy(busy), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .char_out(char_out),
    .char_valid(char_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: predict from the current inputs, compare at the falling edge, advance.
  task automatic tick();
    bit         slot, ewe, eack, evalid;
    logic [12:0] ea;
    logic [7:0]  ed;
    @(negedge clk);
    slot = p_tick && px < 640 && py < 480 && (px % 8) == 0;
    ewe = 0; eack = 0; ea = '0; ed = '0;
    if (slot) ea = 13'(((int'(py) / 16) * 80 + int'(px) / 8) % 8192);
    else if (m_clr) begin ewe = 1; ea = 13'(m_ptr); ed = 8'h20; end
    else if (!clr_req && wr_req) begin ewe = 1; eack = 1; ea = wr_addr; ed = wr_data; end
    if (reset) begin ewe = 0; eack = 0; end
    chk("ram_we", ram_we, ewe);
    chk("wr_ack", wr_ack, eack);
    chk("busy", busy, m_clr && !reset);
    if (!reset) begin
      chk("ram_addr", ram_addr, ea);
      chk("ram_wdata", ram_wdata, ed);
    end
    evalid = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      evalid = 1;
      m_char = rq[0].val;
      void'(rq.pop_front());
    end
    chk("char_valid", char_valid, evalid);
    chk("char_out", char_out, m_char);
    if (wr_ack) dut_acks++;
    if (ram_we && ram_wdata == 8'h20) nclr++;
    if (slot && !reset) rq.push_back('{due: cyc + 2, val: shadow[ea]});
    if (ewe) shadow[ea] = ed;
    if (reset) begin
      m_clr = 0; m_ptr = 0; m_char = 8'h00;
      while (rq.size() > 0 && rq[rq.size()-1].due > cyc) void'(rq.pop_back());
    end else if (m_clr) begin
      if (!slot) begin
        if (m_ptr == CELLS - 1) m_clr = 0;
        m_ptr++;
      end
    end else if (clr_req) begin
      m_clr = 1; m_ptr = 0;
    end
    m_ack = eack;
    cyc++;
    @(posedge clk);
    #1;
    if (m_ack) wr_req = 1'b0;
  endtask

  task automatic tick_scan();
    p_tick = 1'b1;
    tick();
    if (px == 799) begin
      px = 0;
      py = (py == 524) ? 10'd0 : py + 1'b1;
    end else begin
      px = px + 1'b1;
    end
  endtask

  initial begin
    int base;
    for (int i = 0; i < 8192; i++) shadow[i] = 8'h00;
    reset = 1; tb_init = 1; p_tick = 0; px = 0; py = 500;
    wr_req = 1; wr_addr = 13'd5; wr_data = 8'h77; clr_req = 0;
    @(posedge clk); #1;
    tick();
    #2;
    chk("rst_char_valid", char_valid, 0);
    chk("rst_char_out", char_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_ram_we", ram_we, 0);
    tick();
    wr_req = 0; tb_init = 0; reset = 0;
    tick();

    // Seed cell 82 with 'A', then fetch it through a display slot.
    wr_req = 1; wr_addr = 13'd82; wr_data = 8'h41;
    tick();
    px = 16; py = 17; p_tick = 1;
    #2;
    chk("fetch_addr", ram_addr, 82);
    chk("fetch_we", ram_we, 0);
    tick();
    p_tick = 0; tick();
    #2;
    chk("fetch_valid", char_valid, 1);
    chk("fetch_char", char_out, 8'h41);
    tick();

    // Host write raised in a display slot waits one clock.
    px = 24; p_tick = 1; wr_req = 1; wr_addr = 13'd100; wr_data = 8'h5A;
    #2;
    chk("coll_no_ack", wr_ack, 0);
    tick();
    p_tick = 0;
    #2;
    chk("coll_we", ram_we, 1);
    chk("coll_addr", ram_addr, 100);
    chk("coll_wdata", ram_wdata, 8'h5A);
    chk("coll_ack", wr_ack, 1);
    tick();
    #2;
    chk("coll_ack_once", wr_ack, 0);
    tick(); tick();

    // Full clear with display blanked.
    py = 500; p_tick = 0; nclr = 0;
    clr_req = 1; tick(); clr_req = 0;
    for (int i = 0; i < 3000 && m_clr; i++) tick();
    chk("clr_writes", nclr, CELLS);
    chk("clr_busy_done", busy, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("clr_no_extra", nclr, CELLS);

    // Clear during active video with a pending host write.
    px = 0; py = 0;
    clr_req = 1; tick_scan(); clr_req = 0;
    for (int i = 0; i < 9; i++) tick_scan();
    wr_req = 1; wr_addr = 13'd7; wr_data = 8'h33;
    base = dut_acks;
    for (int i = 0; i < 6000 && wr_req; i++) tick_scan();
    for (int i = 0; i < 5; i++) tick_scan();
    chk("vid_single_ack", dut_acks - base, 1);
    chk("vid_busy_done", busy, 0);

    // Reset abandons a clear at count 500; a new clear restarts at 0.
    p_tick = 0; py = 500;
    clr_req = 1; tick(); clr_req = 0;
    for (int i = 0; i < 500; i++) tick();
    reset = 1;
    #2;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_we", ram_we, 0);
    tick();
    reset = 0;
    clr_req = 1; tick(); clr_req = 0;
    #2;
    chk("restart_addr", ram_addr, 0);
    chk("restart_we", ram_we, 1);
    for (int i = 0; i < 3000 && m_clr; i++) tick();

    // Bottom-right cell and the edges of the active area.
    px = 632; py = 479; p_tick = 1;
    #2;
    chk("br_addr", ram_addr, 2399);
    tick();
    px = 640; py = 0; wr_req = 1; wr_addr = 13'd9; wr_data = 8'h11;
    #2;
    chk("x640_no_slot", wr_ack, 1);
    tick();
    px = 0; py = 480; wr_req = 1; wr_addr = 13'd10; wr_data = 8'h12;
    #2;
    chk("y480_no_slot", wr_ack, 1);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      p_tick = 1'($urandom % 2);
      px = ($urandom % 4 == 0) ? 10'(($urandom % 100) * 8) : 10'($urandom % 800);
      py = 10'($urandom % 525);
      if (!wr_req && $urandom % 4 == 0) begin
        wr_req = 1; wr_addr = 13'($urandom); wr_data = 8'($urandom);
      end
      clr_req = ($urandom % 1500 == 0);
      reset = ($urandom % 1500 == 0);
      tick();
      clr_req = 0; reset = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port text-mode video RAM between three users: the display scan, a host writer and an internal clear-screen engine.
- Display reads are driven by the pixel_x/pixel_y/p_tick timing outputs of the 640x480 sync generator.
- Each displayed cell costs exactly one read slot. The writer and the clear engine use every other clock cycle.
- Sits between the sync generator, the character/font pipeline and the host write port.

Parameters:
- ADDR_W, 13: RAM address width.
- DATA_W, 8: RAM data width (character code).
- COLS, 80: text cells per row.
- ROWS, 30: text rows.
- CELL_W_LOG2, 3: log2 of cell width in pixels (8).
- CELL_H_LOG2, 4: log2 of cell height in pixels (16).
- CLR_CHAR, 8'h20: fill value used by the clear operation.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- p_tick, in, 1: pixel enable from the sync generator.
- pixel_x, in, 10: horizontal count.
- pixel_y, in, 10: vertical count.
- wr_req, in, 1: host write request; held until wr_ack.
- wr_addr, in, ADDR_W: host write address; stable while wr_req is high.
- wr_data, in, DATA_W: host write data; stable while wr_req is high.
- wr_ack, out, 1: one-cycle pulse in the cycle the host write is performed.
- clr_req, in, 1: start-clear pulse.
- busy, out, 1: clear in progress.
- ram_addr, out, ADDR_W: RAM address.
- ram_we, out, 1: RAM write enable.
- ram_wdata, out, DATA_W: RAM write data.
- ram_rdata, in, DATA_W: RAM read data, valid 1 clk after the address is presented.
- char_out, out, DATA_W: fetched character code.
- char_valid, out, 1: char_out is valid.

Behaviour:
- **Display slot:**
  - disp_slot = p_tick && pixel_x < 640 && pixel_y < 480 && pixel_x[CELL_W_LOG2-1:0] == 0.
  - In that cycle: ram_addr = (pixel_y >> CELL_H_LOG2) * COLS + (pixel_x >> CELL_W_LOG2), ram_we = 0.
  - Address is computed at full precision and truncated to ADDR_W.
  - Display always wins the slot; the slot is never delayed or skipped.
- **Read return:**
  - char_out is registered from ram_rdata, with char_valid high exactly 2 clks after disp_slot, for 1 clk.
  - char_out holds its value otherwise.
- **FSM, IDLE:**
  - clr_req moves to CLEAR, loads clr_cnt = 0 and sets busy = 1 next cycle.
  - Otherwise, if wr_req && !disp_slot: ram_addr = wr_addr, ram_wdata = wr_data, ram_we = 1, wr_ack = 1 (combinational, same cycle).
- **FSM, CLEAR:**
  - On each !disp_slot cycle: ram_addr = clr_cnt, ram_wdata = CLR_CHAR, ram_we = 1, then clr_cnt increments.
  - When a write to COLS*ROWS-1 occurs, return to IDLE; busy drops the next cycle.
  - Host writes are not acked while in CLEAR, and wr_req stays pending.
  - clr_req during CLEAR is ignored and does not restart the count.
- **Simultaneous events:**
  - clr_req and wr_req together in IDLE: clear wins; the write is acked after the clear completes.
  - wr_req together with disp_slot: no ack that cycle; the ack comes in the next non-slot cycle.
- **Idle defaults:** with no grant, ram_we = 0, ram_wdata = 0, ram_addr = 0.
- **Reset:**
  - Synchronous reset gives FSM = IDLE, clr_cnt = 0, busy = 0, char_valid = 0, char_out = 0.
  - While reset is high: wr_ack = 0 and ram_we = 0.
  - Reset during CLEAR abandons the clear; RAM contents are left partially cleared.
- **Guarantee:** the worst-case host wait outside CLEAR is 2 clks when p_tick is high every cycle (at most 1 display slot per 2^CELL_W_LOG2 ticks).

Test Plan:
- **Display fetch:** p_tick every 2nd clk, pixel_y = 17, pixel_x = 16 on a tick; ram_rdata = 8'h41 the next clk → ram_addr = 82, ram_we = 0; char_valid = 1 and char_out = 8'h41 two clks after the slot.
- **Write collision:** wr_req, addr 100, data 8'h5A raised in a disp_slot cycle → no wr_ack that cycle; next clk ram_we = 1, ram_addr = 100, ram_wdata = 8'h5A, wr_ack = 1 for exactly 1 clk.
- **Clear, no display:** clr_req pulse with pixel_y = 500 → busy = 1; 2400 writes of 8'h20 to addresses 0..2399 in order; busy = 0 after the last; no writes beyond 2399.
- **Clear during active video:** clr_req, then 10 clks later wr_req → every display slot still issues reads; no wr_ack until busy falls; then a single wr_ack.
- **Reset mid-clear:** reset for 1 clk while clr_cnt = 500 → busy = 0, ram_we = 0 during reset; a new clr_req restarts from address 0.
- **Bottom-right cell and idle region:** pixel_x = 632, pixel_y = 479 → ram_addr = 2399. Also check that no slot occurs at pixel_x = 640 or pixel_y = 480.
